seg7_rx_decoder: RTL and testbench

- Receive-side counterpart of the seven-segment encoder in the display path.
- Samples seven asynchronous segment lines `seg_a`..`seg_g`, requires each pattern to be stable before accepting it, and maps it back to a 4-bit hex value.
- Presents the value on a valid/ready handshake and flags unrecognised glyphs.
- Sits between the display encoder outputs and a checker or host consumer, so encoded displays can be read back in-system.

---
 rtl/seg7_rx_decoder.sv | 199 +++++++++++++++++++
 tb/tb_seg7_rx_decoder.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/seg7_rx_decoder.sv
// Seven-segment receive decoder: synchronise, debounce, decode to hex, valid/ready out.
// Latency: STABLE_CYCLES+3 edges from a stable pattern to out_valid/code_err.
// Backpressure: one-entry holding register; a new value replaces an unconsumed one and pulses overrun.
// Optional feature macro: SEG7_RX_ERRCNT_EN (saturating error counter on err_count).
module seg7_rx_decoder #(
    parameter int unsigned STABLE_CYCLES  = 4,
    parameter bit          SEG_ACTIVE_LOW = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       seg_a,
    input  logic       seg_b,
    input  logic       seg_c,
    input  logic       seg_d,
    input  logic       seg_e,
    input  logic       seg_f,
    input  logic       seg_g,
    output logic [3:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       code_err,
    output logic       overrun,
    output logic [7:0] err_count
);

    localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES);
    localparam logic [7:0] ACC_AT  = 8'(STABLE_CYCLES - 1);
    localparam logic [6:0] BLANK   = 7'b0000000;

    typedef enum logic {
        TRACK = 1'b0,
        PEND  = 1'b1
    } state_t;

    typedef struct packed {
        logic       hit;
        logic [3:0] val;
    } glyph_t;

    function automatic glyph_t glyph_lookup(input logic [6:0] p);
        glyph_t g;
        g.hit = 1'b1;
        g.val = 4'h0;
        case (p)
            7'b1111110: g.val = 4'h0;
            7'b0110000: g.val = 4'h1;
            7'b1101101: g.val = 4'h2;
            7'b1111001: g.val = 4'h3;
            7'b0110011: g.val = 4'h4;
            7'b1011011: g.val = 4'h5;
            7'b1011111: g.val = 4'h6;
            7'b1110000: g.val = 4'h7;
            7'b1111111: g.val = 4'h8;
            7'b1111011: g.val = 4'h9;
            7'b1110111: g.val = 4'hA;
            7'b0011111: g.val = 4'hB;
            7'b1001110: g.val = 4'hC;
            7'b0111101: g.val = 4'hD;
            7'b1001111: g.val = 4'hE;
            7'b1000111: g.val = 4'hF;
            default:    g.hit = 1'b0;
        endcase
        return g;
    endfunction

    logic [6:0] seg_raw;
    logic [6:0] sync1_q;
    logic [6:0] sync2_q;
    logic [6:0] s;
    logic [6:0] prev_q;
    logic [7:0] cnt_q;
    logic [6:0] last_pat_q;
    logic       accept;
    glyph_t     glyph;

    logic       acc_vld_q;
    logic       acc_err_q;
    logic [3:0] acc_dat_q;

    state_t     state_q;
    state_t     state_d;
    logic       overrun_d;
    logic [3:0] out_data_q;
    logic       code_err_q;
    logic       overrun_q;

    assign seg_raw = {seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g};
    assign s       = sync2_q ^ {7{SEG_ACTIVE_LOW}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= seg_raw;
            sync2_q <= sync1_q;
        end
    end

    // prev_q holds the sample the counter has been matching, so it is the stable pattern at accept time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= '0;
            cnt_q  <= '0;
        end else begin
            prev_q <= s;
            if (s == prev_q) begin
                if (cnt_q != CNT_MAX) begin
                    cnt_q <= cnt_q + 8'd1;
                end
            end else begin
                cnt_q <= '0;
            end
        end
    end

    assign accept = (cnt_q == ACC_AT) && (prev_q != last_pat_q);
    assign glyph  = glyph_lookup(prev_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_pat_q <= BLANK;
            acc_vld_q  <= 1'b0;
            acc_err_q  <= 1'b0;
            acc_dat_q  <= '0;
        end else begin
            acc_vld_q <= 1'b0;
            acc_err_q <= 1'b0;
            if (accept) begin
                last_pat_q <= prev_q;
                if (prev_q != BLANK) begin
                    acc_vld_q <= glyph.hit;
                    acc_err_q <= !glyph.hit;
                    acc_dat_q <= glyph.val;
                end
            end
        end
    end

    // A same-cycle consume frees the slot, so only an unconsumed pending value counts as overrun.
    always_comb begin
        state_d   = state_q;
        overrun_d = 1'b0;
        case (state_q)
            TRACK: begin
                if (acc_vld_q) begin
                    state_d = PEND;
                end
            end
            PEND: begin
                if (acc_vld_q) begin
                    state_d   = PEND;
                    overrun_d = !out_ready;
                end else if (out_ready) begin
                    state_d = TRACK;
                end
            end
            default: state_d = TRACK;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= TRACK;
            out_data_q <= '0;
            code_err_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            code_err_q <= acc_err_q;
            overrun_q  <= overrun_d;
            if (acc_vld_q) begin
                out_data_q <= acc_dat_q;
            end
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = (state_q == PEND);
    assign code_err  = code_err_q;
    assign overrun   = overrun_q;

`ifdef SEG7_RX_ERRCNT_EN
    logic [7:0] err_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else if ((acc_err_q || overrun_d) && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign err_count = err_cnt_q;
`else
    assign err_count = 8'h00;
`endif

endmodule

// File: tb/tb_seg7_rx_decoder.sv
// Directed bench for seg7_rx_decoder: latency, glitch rejection, back-pressure, bad glyphs, repeats, reset.
module tb_seg7_rx_decoder;

    localparam logic [6:0] P_BLANK = 7'b0000000;
    localparam logic [6:0] P_0     = 7'b1111110;
    localparam logic [6:0] P_1     = 7'b0110000;
    localparam logic [6:0] P_3     = 7'b1111001;
    localparam logic [6:0] P_5     = 7'b1011011;
    localparam logic [6:0] P_8     = 7'b1111111;
    localparam logic [6:0] P_BAD   = 7'b1010101;

`ifdef SEG7_RX_ERRCNT_EN
    localparam logic [7:0] ERR1 = 8'd1;
`else
    localparam logic [7:0] ERR1 = 8'd0;
`endif

    logic       clk;
    logic       rst_n;
    logic       seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g;
    logic [3:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       code_err;
    logic       overrun;
    logic [7:0] err_count;

    int n_cmp = 0;
    int n_err = 0;
    int v_cnt, e_cnt, o_cnt, x_cnt;
    logic [3:0] x_dat;

    seg7_rx_decoder #(
        .STABLE_CYCLES (4),
        .SEG_ACTIVE_LOW(1'b0)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .seg_a    (seg_a),
        .seg_b    (seg_b),
        .seg_c    (seg_c),
        .seg_d    (seg_d),
        .seg_e    (seg_e),
        .seg_f    (seg_f),
        .seg_g    (seg_g),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .code_err (code_err),
        .overrun  (overrun),
        .err_count(err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic show(input logic [6:0] p);
        {seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g} = p;
    endtask

    task automatic watch(input int n);
        v_cnt = 0;
        e_cnt = 0;
        o_cnt = 0;
        x_cnt = 0;
        repeat (n) begin
            tick(1);
            if (out_valid) v_cnt++;
            if (code_err) e_cnt++;
            if (overrun) o_cnt++;
            if (out_valid && out_ready) begin
                x_cnt++;
                x_dat = out_data;
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_data"}, 32'(out_data), 32'd0);
        check({tag, "_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_err"}, 32'(code_err), 32'd0);
        check({tag, "_ovr"}, 32'(overrun), 32'd0);
        check({tag, "_cnt"}, 32'(err_count), 32'd0);
    endtask

    initial begin
        x_dat     = '0;
        rst_n     = 1'b0;
        out_ready = 1'b1;
        show(P_BLANK);
        tick(3);
        check_all_zero("reset");

        // Basic decode: pattern set up before edge 0, valid after edge 7 for one cycle.
        rst_n = 1'b1;
        show(P_3);
        tick(7);
        check("lat_pre", 32'(out_valid), 32'd0);
        tick(1);
        check("lat_valid", 32'(out_valid), 32'd1);
        check("lat_data", 32'(out_data), 32'd3);
        tick(1);
        check("one_cycle", 32'(out_valid), 32'd0);

        // Glitch rejection: three-sample pulse between blanks.
        show(P_BLANK);
        watch(12);
        check("blank_no_out", 32'(v_cnt), 32'd0);
        show(P_1);
        tick(3);
        show(P_BLANK);
        watch(15);
        check("glitch_valid", 32'(v_cnt), 32'd0);
        check("glitch_err", 32'(e_cnt), 32'd0);

        // Back-pressure: 0, blank, 8 with consumer stalled.
        out_ready = 1'b0;
        show(P_0);
        watch(10);
        check("bp_no_ovr0", 32'(o_cnt), 32'd0);
        check("bp_valid0", 32'(out_valid), 32'd1);
        check("bp_data0", 32'(out_data), 32'd0);
        show(P_BLANK);
        watch(12);
        check("bp_hold_valid", 32'(out_valid), 32'd1);
        check("bp_hold_data", 32'(out_data), 32'd0);
        show(P_8);
        watch(12);
        check("bp_ovr_once", 32'(o_cnt), 32'd1);
        check("bp_valid8", 32'(out_valid), 32'd1);
        check("bp_data8", 32'(out_data), 32'd8);
        check("bp_errcnt", 32'(err_count), 32'(ERR1));
        out_ready = 1'b1;
        #1;
        check("bp_ready_no_comb", 32'(out_valid), 32'd1);
        tick(1);
        check("bp_consumed", 32'(out_valid), 32'd0);

        // Invalid glyph from a fresh reset: one code_err for a long hold.
        rst_n = 1'b0;
        #1;
        check("rst2_cnt", 32'(err_count), 32'd0);
        tick(2);
        rst_n = 1'b1;
        tick(10);
        show(P_BAD);
        tick(7);
        check("bad_pre", 32'(code_err), 32'd0);
        tick(1);
        check("bad_pulse", 32'(code_err), 32'd1);
        check("bad_no_valid", 32'(out_valid), 32'd0);
        watch(19);
        check("bad_once", 32'(e_cnt), 32'd0);
        check("bad_no_valid_hold", 32'(v_cnt), 32'd0);
        check("bad_errcnt", 32'(err_count), 32'(ERR1));

        // Repeat digit: 5, blank, 5 gives two transfers; a continuous hold gives one.
        show(P_BLANK);
        watch(10);
        show(P_5);
        watch(12);
        check("rep_xfer1", 32'(x_cnt), 32'd1);
        check("rep_data1", 32'(x_dat), 32'd5);
        show(P_BLANK);
        watch(10);
        check("rep_blank", 32'(x_cnt), 32'd0);
        show(P_5);
        watch(30);
        check("rep_xfer2", 32'(x_cnt), 32'd1);
        check("rep_data2", 32'(x_dat), 32'd5);

        // Async reset while a value is pending, digit held through it.
        out_ready = 1'b0;
        show(P_BLANK);
        watch(10);
        show(P_5);
        watch(10);
        check("ar_valid", 32'(out_valid), 32'd1);
        check("ar_data", 32'(out_data), 32'd5);
        #3;
        rst_n = 1'b0;
        #1;
        check_all_zero("ar_reset");
        tick(1);
        rst_n = 1'b1;
        tick(7);
        check("ar_lat_pre", 32'(out_valid), 32'd0);
        tick(1);
        check("ar_lat_valid", 32'(out_valid), 32'd1);
        check("ar_lat_data", 32'(out_data), 32'd5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
